// File: rtl/multi_ctrl_fork_fifo_pkg.sv
// Shared definitions for the two-lane fork FIFO feeding the multi-control pipe.
package multi_ctrl_fork_fifo_pkg;

  // Number of downstream consumer lanes sharing the data bus.
  localparam int NLANE = 2;

  // One bit per lane; bit0 = lane 0, bit1 = lane 1.
  typedef logic [NLANE-1:0] lane_mask_t;

  // The occupancy counter has one extra bit so that full and empty differ.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/multi_ctrl_fifo_mem.sv
// Register array for the fork FIFO: one synchronous write port and one
// asynchronous read port. The contents are never reset.
module multi_ctrl_fifo_mem #(
  parameter int ENTRY_W = 258,
  parameter int DEPTH   = 4,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The head entry is visible without a clock of latency.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/multi_ctrl_fork_fifo.sv
// Fork FIFO: buffers masked beats and offers each head entry to both lanes.
// The entry retires once every lane named in its mask has taken it.
//
// Handshake rules (upstream and both downstream lanes): a beat transfers on a
// rising edge where valid and ready are both high. A valid, once raised, holds
// with stable data until it transfers; ready may change freely. Upstream ready
// depends combinationally on downstream ready (a pop frees a slot for a push
// in the same cycle).
module multi_ctrl_fork_fifo
  import multi_ctrl_fork_fifo_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [1:0]        s_mask,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [1:0]        b_valid_out,
  output logic [DATA_W-1:0] b_data_out,
  input  logic [1:0]        b_ready_in,
  output logic [CNT_W-1:0]  level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + NLANE;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  lane_mask_t         served;

  logic [ENTRY_W-1:0] head_entry;
  lane_mask_t         head_mask;
  lane_mask_t         fire;
  lane_mask_t         done;
  logic               not_empty;
  logic               full;
  logic               push;
  logic               pop;

  multi_ctrl_fifo_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .AW      (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({s_mask, s_data}),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  // Head presentation, per-lane fire, retire decision and upstream ready.
  // A lane that already took the head is masked off via served; lanes not in
  // the head mask count as done from the start.
  always_comb begin
    head_mask   = head_entry[ENTRY_W-1 -: NLANE];
    b_data_out  = head_entry[DATA_W-1:0];
    not_empty   = (count != '0);
    full        = (count == CNT_W'(DEPTH));
    b_valid_out = not_empty ? (head_mask & ~served) : 2'b00;
    fire        = b_valid_out & b_ready_in;
    done        = served | fire | ~head_mask;
    pop         = not_empty & (done == 2'b11);
    s_ready     = ~full | pop;
    push        = s_valid & s_ready & (s_mask != 2'b00);
    level       = count;
  end

  // Pointers, occupancy and per-lane served flags. A zero-mask beat
  // handshakes upstream but never reaches storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      served <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop) served <= '0;
      else     served <= served | fire;
    end
  end

endmodule

// File: tb/tb_multi_ctrl_fork_fifo.sv
// Bench for the fork FIFO: directed beats, per-lane expected queues checked by
// an independent monitor, plus direct checks on level / ready / valid.
module tb_multi_ctrl_fork_fifo;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic [1:0]        s_mask;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [1:0]        b_valid_out;
  logic [DATA_W-1:0] b_data_out;
  logic [1:0]        b_ready_in;
  logic [CNT_W-1:0]  level;

  int vectors;
  int miscompares;

  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];

  logic [1:0]        prev_pend;
  logic [DATA_W-1:0] prev_data;

  multi_ctrl_fork_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_mask      (s_mask),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .b_valid_out (b_valid_out),
    .b_data_out  (b_data_out),
    .b_ready_in  (b_ready_in),
    .level       (level)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generic comparison with a name for the report.
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one upstream beat; record expected per-lane outputs on acceptance.
  task automatic send(input logic [1:0] m, input logic [DATA_W-1:0] d);
    int  waited;
    bit  ok;
    waited  = 0;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_mask  = m;
    s_data  = d;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        if (m[0]) exp_q0.push_back(d);
        if (m[1]) exp_q1.push_back(d);
      end
      @(posedge clk); #1;
      waited++;
    end
    s_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: beat %0h not accepted within 50 cycles", d);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: per-lane data against expected queues, plus hold/stability of
  // any lane that was valid but not taken on the previous sample.
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (prev_pend[i]) begin
          chk($sformatf("hold_valid_lane%0d", i), DATA_W'(b_valid_out[i]), DATA_W'(1));
          chk($sformatf("hold_data_lane%0d", i), b_data_out, prev_data);
        end
      end
      if (b_valid_out[0] && b_ready_in[0]) begin
        if (exp_q0.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL lane0_unexpected: got %0h expected nothing", b_data_out);
        end else begin
          chk("lane0_data", b_data_out, exp_q0.pop_front());
        end
      end
      if (b_valid_out[1] && b_ready_in[1]) begin
        if (exp_q1.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL lane1_unexpected: got %0h expected nothing", b_data_out);
        end else begin
          chk("lane1_data", b_data_out, exp_q1.pop_front());
        end
      end
      prev_pend = b_valid_out & ~b_ready_in;
      prev_data = b_data_out;
    end
  end

  // Directed stimulus sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_pend   = 2'b00;
    prev_data   = '0;
    rst         = 1'b0;
    s_valid     = 1'b0;
    s_mask      = 2'b00;
    s_data      = '0;
    b_ready_in  = 2'b00;

    // Reset state.
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", DATA_W'(b_valid_out), DATA_W'(0));
    chk("rst_level", DATA_W'(level), DATA_W'(0));
    chk("rst_s_ready", DATA_W'(s_ready), DATA_W'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic broadcast.
    b_ready_in = 2'b11;
    send(2'b11, DATA_W'(8'hA5));
    chk("bcast_valid", DATA_W'(b_valid_out), DATA_W'(2'b11));
    chk("bcast_level1", DATA_W'(level), DATA_W'(1));
    cycles(1);
    chk("bcast_level0", DATA_W'(level), DATA_W'(0));

    // Skewed consumers.
    b_ready_in = 2'b01;
    send(2'b11, DATA_W'(8'h11));
    chk("skew_valid_both", DATA_W'(b_valid_out), DATA_W'(2'b11));
    cycles(1);
    chk("skew_valid_l1", DATA_W'(b_valid_out), DATA_W'(2'b10));
    chk("skew_level", DATA_W'(level), DATA_W'(1));
    cycles(1);
    chk("skew_valid_l1_hold", DATA_W'(b_valid_out), DATA_W'(2'b10));
    b_ready_in = 2'b10;
    cycles(1);
    chk("skew_retired_level", DATA_W'(level), DATA_W'(0));
    chk("skew_retired_valid", DATA_W'(b_valid_out), DATA_W'(0));

    // Single-lane and null masks.
    b_ready_in = 2'b00;
    send(2'b10, DATA_W'(8'h22));
    send(2'b00, DATA_W'(8'h33));
    send(2'b01, DATA_W'(8'h44));
    chk("mask_level", DATA_W'(level), DATA_W'(2));
    chk("mask_head_valid", DATA_W'(b_valid_out), DATA_W'(2'b10));
    b_ready_in = 2'b11;
    cycles(3);
    chk("mask_drained", DATA_W'(level), DATA_W'(0));

    // Full, wrap-around, and push into a full FIFO with simultaneous pop.
    b_ready_in = 2'b00;
    for (int k = 1; k <= 4; k++) send(2'b11, DATA_W'(k));
    chk("full_level", DATA_W'(level), DATA_W'(4));
    chk("full_s_ready", DATA_W'(s_ready), DATA_W'(0));
    b_ready_in = 2'b11;
    #1;
    chk("full_pop_s_ready", DATA_W'(s_ready), DATA_W'(1));
    send(2'b11, DATA_W'(5));
    chk("full_pushpop_level5", DATA_W'(level), DATA_W'(4));
    send(2'b11, DATA_W'(6));
    chk("full_pushpop_level6", DATA_W'(level), DATA_W'(4));
    cycles(5);
    chk("wrap_drained", DATA_W'(level), DATA_W'(0));

    // Reset mid-operation with lane 0 already served on the head.
    b_ready_in = 2'b00;
    send(2'b11, DATA_W'(8'h55));
    send(2'b11, DATA_W'(8'h66));
    send(2'b11, DATA_W'(8'h88));
    b_ready_in = 2'b01;
    cycles(1);
    b_ready_in = 2'b00;
    chk("pre_rst_level", DATA_W'(level), DATA_W'(3));
    chk("pre_rst_valid", DATA_W'(b_valid_out), DATA_W'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", DATA_W'(b_valid_out), DATA_W'(0));
    chk("midrst_level", DATA_W'(level), DATA_W'(0));
    chk("midrst_s_ready", DATA_W'(s_ready), DATA_W'(1));
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_valid", DATA_W'(b_valid_out), DATA_W'(0));
    b_ready_in = 2'b11;
    send(2'b11, DATA_W'(8'h77));
    cycles(3);
    chk("post_rst_level", DATA_W'(level), DATA_W'(0));

    // Everything pushed must have been consumed.
    chk("lane0_leftover", DATA_W'(exp_q0.size()), DATA_W'(0));
    chk("lane1_leftover", DATA_W'(exp_q1.size()), DATA_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_ctrl_fork_fifo.md
Name: multi_ctrl_fork_fifo

Overview:
- Upstream feeder for the two-lane multi-control pipe stages (shared data bus, per-lane valid/ready).
- Accepts a single-lane valid/ready stream where each beat carries a 2-bit lane mask, and buffers the beats in a DEPTH-entry FIFO.
- Presents the FIFO head to both lanes. Each enabled lane consumes the head independently. The entry retires only after every lane in its mask has completed its handshake.

Parameters:
- DATA_W, 256, width of the shared data bus.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- clk  input  1  clock; every flop is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream beat valid.
- s_mask  input  2  lanes that must consume this beat; bit0 = lane 0, bit1 = lane 1.
- s_data  input  DATA_W  upstream beat data.
- s_ready  output  1  upstream ready.
- b_valid_out  output  2  per-lane valid toward the downstream multi-control stage.
- b_data_out  output  DATA_W  FIFO head data, shared by both lanes.
- b_ready_in  input  2  per-lane ready from the downstream stage.
- level  output  CNT_W  current FIFO occupancy (0..DEPTH).

Behaviour:
- Reset, asynchronous on rst=1:
  - wr_ptr, rd_ptr, count, served[1:0] all clear to 0.
  - Outputs: b_valid_out=2'b00, s_ready=1, level=0.
  - The data RAM is not reset; b_data_out is don't-care while the FIFO is empty.
- Storage:
  - Entries hold {mask[1:0], data}.
  - Pointers have log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is CNT_W bits and distinguishes full from empty.
- Push:
  - push = s_valid & s_ready & (s_mask != 0). On push, the entry is written at wr_ptr and wr_ptr increments.
  - A beat with s_mask==2'b00 handshakes when s_ready=1 and is discarded; nothing is written and count is unchanged.
- s_ready = (count != DEPTH) | pop.
  - Same-cycle pop allows a push into a full FIFO.
  - This makes a combinational path from b_ready_in to s_ready; this path is accepted.
- Head valid: b_valid_out = (count != 0) ? (head_mask & ~served) : 2'b00.
- Lane fire: fire[i] = b_valid_out[i] & b_ready_in[i].
- Pop:
  - done = served | fire | ~head_mask.
  - pop = (count != 0) & (done == 2'b11).
  - On pop, rd_ptr increments and served clears to 0. Otherwise served <= served | fire.
- Per-lane valid must not drop before its own handshake. Once a lane fires it deasserts the next cycle, while the other lane may still be pending.
- Data stability: b_data_out is stable while any head lane is valid and not yet fired.
- Simultaneous push and pop:
  - count is unchanged; both pointers advance.
  - Full with pop: the push is accepted.
  - Empty: no pop is possible, because the head is not valid in the same cycle as the write; there is no bypass.
- Latency: a beat pushed in cycle N is visible on b_valid_out in cycle N+1 at the earliest.
- Throughput: one beat per cycle when all masked lanes are ready.
- level = count, registered.
- Reset mid-operation: all buffered entries and partial served state are dropped immediately. No spurious valid after reset deasserts.

Decomposition:
- Shared package: lane count constant NLANE=2, a lane-mask typedef, and a helper function for the counter width.
- One sub-module is natural: multi_ctrl_fifo_mem, a DEPTH×(DATA_W+2) register array with one write port and an asynchronous read port.
- Pointer, count and served logic stay in the top module.

Test Plan:
- Basic broadcast: push data 0xA5, mask 11, with b_ready_in=11 throughout.
  - Expect b_valid_out=11 the next cycle with data 0xA5; one cycle later level returns to 0.
- Skewed consumers: push 0x11 (mask 11), then hold b_ready_in=01 for 3 cycles and 10 after that.
  - Expect lane 0 to fire once and b_valid_out to become 10.
  - The entry retires only on the lane-1 fire, and 0x11 stays stable throughout.
- Single-lane and null masks: push 0x22 (mask 10), 0x33 (mask 00), 0x44 (mask 01).
  - Expect only lane 1 to see 0x22 and only lane 0 to see 0x44; 0x33 never appears.
  - level never exceeds 2.
- Full and wrap-around: with DEPTH=4, push 6 beats 0x1..0x6 with b_ready_in=00.
  - Expect s_ready=0 once level=4.
  - Then release b_ready_in=11: expect data 1..6 in order with no loss, across pointer wrap.
- Full with simultaneous push and pop: at level=4 with b_ready_in=11 and s_valid=1.
  - Expect s_ready=1 and level to stay at 4 for consecutive cycles.
- Reset mid-operation: with level=3 and served=01, assert rst asynchronously.
  - Expect b_valid_out=00, level=0 and s_ready=1 immediately.
  - After rst deasserts, a new push of 0x77 emerges first.
